keypad_scanner: RTL and testbench

- Drives the row side of the 4x3 safe keypad and samples the column lines, one row at a time.
- Produces a debounced, single-pulse key event with a 4-bit key code.
- Feeds the safe's key-entry logic with clean one-cycle strobes, replacing raw asynchronous row/column levels as the press source.
- Star and sharp are reported as distinct codes.

---
 rtl/keypad_scanner.sv | 190 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Row-scanned 4x3 keypad front end: drives one row at a time, samples the columns,
// debounces whole-scan results and emits a one-cycle key strobe with a 4-bit code.
module keypad_scanner #(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] col_in,
    output logic [3:0] row_out,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held,
    output logic       multi_key
);

    localparam int              DW         = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0]      DEB_N      = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        DEB_RELEASE
    } state_t;

    logic [2:0]    col_p0;
    logic [2:0]    col_p1;
    logic [DW-1:0] dwell_cnt;
    logic [1:0]    row_idx;
    logic [8:0]    scan_acc;
    logic          sample;
    logic          scan_end;
    logic [11:0]   scan_bits;
    logic [3:0]    bit_cnt;
    logic [3:0]    hit_code;
    logic          is_none;
    logic          is_single;
    logic          is_multi;

    state_t        state;
    logic [3:0]    cand;
    logic [3:0]    deb_cnt;

    // Bit index is row*3 + col (both zero-based); row 4 carries star, 0, sharp.
    function automatic logic [3:0] key_map(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd2;
            4'd2:    code = 4'd3;
            4'd3:    code = 4'd4;
            4'd4:    code = 4'd5;
            4'd5:    code = 4'd6;
            4'd6:    code = 4'd7;
            4'd7:    code = 4'd8;
            4'd8:    code = 4'd9;
            4'd9:    code = 4'd10;
            4'd10:   code = 4'd0;
            4'd11:   code = 4'd11;
            default: code = 4'd0;
        endcase
        return code;
    endfunction

    assign sample    = (dwell_cnt == DWELL_LAST);
    assign scan_end  = sample && (row_idx == 2'd3);
    // Row 4 is judged straight from the synchronizer on its own sample cycle.
    assign scan_bits = {col_p1, scan_acc};

    always_comb begin
        bit_cnt  = 4'd0;
        hit_code = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (scan_bits[i]) begin
                bit_cnt  = bit_cnt + 4'd1;
                hit_code = key_map(4'(i));
            end
        end
    end

    assign is_none   = (bit_cnt == 4'd0);
    assign is_single = (bit_cnt == 4'd1);
    assign is_multi  = (bit_cnt > 4'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_p0    <= '0;
            col_p1    <= '0;
            dwell_cnt <= '0;
            row_idx   <= 2'd0;
            row_out   <= 4'b0001;
            scan_acc  <= '0;
        end else begin
            col_p0 <= col_in;
            col_p1 <= col_p0;
            if (sample) begin
                dwell_cnt <= '0;
                row_idx   <= row_idx + 2'd1;
                row_out   <= {row_out[2:0], row_out[3]};
                case (row_idx)
                    2'd0:    scan_acc[2:0] <= col_p1;
                    2'd1:    scan_acc[5:3] <= col_p1;
                    2'd2:    scan_acc[8:6] <= col_p1;
                    default: scan_acc      <= '0;
                endcase
            end else begin
                dwell_cnt <= dwell_cnt + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= 4'd0;
            deb_cnt   <= 4'd0;
            key_valid <= 1'b0;
            key_code  <= 4'd0;
            key_held  <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            multi_key <= 1'b0;
            if (scan_end) begin
                multi_key <= is_multi;
                case (state)
                    IDLE: begin
                        if (is_single) begin
                            cand    <= hit_code;
                            deb_cnt <= 4'd1;
                            if (DEB_N == 4'd1) begin
                                state     <= PRESSED;
                                key_code  <= hit_code;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end else begin
                                state <= DEB_PRESS;
                            end
                        end
                    end
                    DEB_PRESS: begin
                        if (is_single && (hit_code == cand)) begin
                            if (deb_cnt + 4'd1 == DEB_N) begin
                                state     <= PRESSED;
                                key_code  <= cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end else begin
                                deb_cnt <= deb_cnt + 4'd1;
                            end
                        end else if (is_single) begin
                            cand    <= hit_code;
                            deb_cnt <= 4'd1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    PRESSED: begin
                        // Extra keys while held are ignored; only a clean release re-arms.
                        if (is_none) begin
                            if (DEB_N == 4'd1) begin
                                state    <= IDLE;
                                key_held <= 1'b0;
                            end else begin
                                state   <= DEB_RELEASE;
                                deb_cnt <= 4'd1;
                            end
                        end
                    end
                    DEB_RELEASE: begin
                        if (is_none) begin
                            if (deb_cnt + 4'd1 == DEB_N) begin
                                state    <= IDLE;
                                key_held <= 1'b0;
                            end else begin
                                deb_cnt <= deb_cnt + 4'd1;
                            end
                        end else begin
                            state <= PRESSED;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: directed key patterns with hand-computed event cycles.
module tb_keypad_scanner;

    logic       clk;
    logic       rst;
    logic [2:0] col_in;
    logic [3:0] row_out;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;
    logic       multi_key;

    logic [11:0] key_mask;
    int          cyc;
    int          checks;
    int          errors;
    logic        prev_held;

    typedef struct packed {
        logic [1:0]  kind;
        logic [3:0]  code;
        logic [31:0] at;
    } ev_t;

    localparam logic [1:0] K_VALID = 2'd0;
    localparam logic [1:0] K_MULTI = 2'd1;
    localparam logic [1:0] K_REL   = 2'd2;

    ev_t sb[$];

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held),
        .multi_key (multi_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a closed switch connects the driven row to its column.
    always_comb begin
        col_in = 3'b000;
        for (int r = 0; r < 4; r++)
            if (row_out[r]) col_in = col_in | key_mask[r*3 +: 3];
    end

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [3:0] code, input int at);
        ev_t e;
        e.kind = kind;
        e.code = code;
        e.at   = 32'(at);
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [1:0] kind, input logic [3:0] code);
        ev_t act;
        ev_t exp;
        act.kind = kind;
        act.code = code;
        act.at   = 32'(cyc);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got kind %0d code %0d at cyc %0d, expected no event",
                     kind, code, cyc);
        end else begin
            exp = sb.pop_front();
            if (act !== exp)begin
                errors++;
                $display("FAIL sb_event: got kind %0d code %0d cyc %0d, expected kind %0d code %0d cyc %0d",
                         act.kind, act.code, act.at, exp.kind, exp.code, exp.at);
            end
        end
    endtask

    // Monitor: every observable event is matched against the head of the queue.
    initial prev_held = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_held = 1'b0;
        end else begin
            if (key_valid)             sb_check(K_VALID, key_code);
            if (multi_key)             sb_check(K_MULTI, 4'd0);
            if (prev_held && !key_held) sb_check(K_REL, 4'd0);
            prev_held = key_held;
        end
    end

    task automatic wait_cyc(input int t);
        int guard;
        guard = 0;
        while (cyc < t && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < t) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout: got cyc %0d expected %0d", cyc, t);
        end
    endtask

    task automatic check_rows(input int n);
        for (int k = 0; k < n; k++) begin
            chk("row_seq", {28'd0, row_out}, 32'(4'b0001 << ((cyc / 4) % 4)));
            @(negedge clk);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        key_mask = '0;
        rst      = 1'b0;
        #1 rst   = 1'b1;
        #1;
        chk("reset_row", {28'd0, row_out}, 32'h1);
        chk("reset_valid", {31'd0, key_valid}, 32'd0);
        chk("reset_held", {31'd0, key_held}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle scanning: row pattern and no events for >200 cycles.
        check_rows(32);
        wait_cyc(208);

        // Key 5 held for scans 14..19.
        push(K_VALID, 4'd5, 240);
        push(K_REL,   4'd0, 336);
        key_mask = 12'b0000_0001_0000;
        wait_cyc(304);
        key_mask = '0;

        // Star, then sharp, each with a clean release.
        wait_cyc(336);
        push(K_VALID, 4'd10, 368);
        push(K_REL,   4'd0,  416);
        key_mask = 12'b0010_0000_0000;
        wait_cyc(384);
        key_mask = '0;
        wait_cyc(416);
        push(K_VALID, 4'd11, 448);
        push(K_REL,   4'd0,  496);
        key_mask = 12'b1000_0000_0000;
        wait_cyc(464);
        key_mask = '0;

        // Bouncing key 7: present, absent, present, present.
        wait_cyc(496);
        push(K_VALID, 4'd7, 560);
        push(K_REL,   4'd0, 592);
        key_mask = 12'b0000_0100_0000;
        wait_cyc(512);
        key_mask = '0;
        wait_cyc(528);
        key_mask = 12'b0000_0100_0000;
        wait_cyc(560);
        key_mask = '0;

        // Keys 1 and 9 together for three scans.
        wait_cyc(592);
        push(K_MULTI, 4'd0, 608);
        push(K_MULTI, 4'd0, 624);
        push(K_MULTI, 4'd0, 640);
        key_mask = 12'b0001_0000_0001;
        wait_cyc(640);
        key_mask = '0;

        // Key 2 held, key 3 added, key 2 lifted, then all released.
        wait_cyc(656);
        push(K_VALID, 4'd2, 688);
        push(K_MULTI, 4'd0, 720);
        push(K_MULTI, 4'd0, 736);
        push(K_REL,   4'd0, 800);
        key_mask = 12'b0000_0000_0010;
        wait_cyc(704);
        key_mask = 12'b0000_0000_0110;
        wait_cyc(736);
        key_mask = 12'b0000_0000_0100;
        wait_cyc(768);
        key_mask = '0;
        wait_cyc(769);
        chk("hold_code", {28'd0, key_code}, 32'd2);
        chk("hold_held", {31'd0, key_held}, 32'd1);

        // Reset during key 8 debounce, in the row-2 dwell of the second scan.
        wait_cyc(816);
        key_mask = 12'b0000_1000_0000;
        wait_cyc(838);
        #2 rst = 1'b1;
        #1;
        chk("arst_row", {28'd0, row_out}, 32'h1);
        chk("arst_code", {28'd0, key_code}, 32'd0);
        chk("arst_valid", {31'd0, key_valid}, 32'd0);
        chk("arst_held", {31'd0, key_held}, 32'd0);
        chk("arst_multi", {31'd0, multi_key}, 32'd0);
        key_mask = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_rows(16);
        wait_cyc(96);
        chk("post_code", {28'd0, key_code}, 32'd0);
        chk("post_held", {31'd0, key_held}, 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
